// File: rtl/inst_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns PC, IR and the retire counter,
// steps each instruction through FETCH/DECODE/EXEC/MEM/WB, gates register
// file writes and data memory accesses, and resolves the next PC from the
// branch controls captured in EXEC.
module inst_seq_ctrl #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  input  logic            rw,
  input  logic            mw,
  input  logic [1:0]      md,
  input  logic [1:0]      bs,
  input  logic            ps,
  input  logic            zero,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] reg_target,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic [31:0]     instret,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e          state_q, state_d;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     instret_q, instret_d;

  logic            taken_q, taken_d;
  logic [1:0]      bsLat_q, bsLat_d;
  logic            rwLat_q, rwLat_d;
  logic            mwLat_q, mwLat_d;
  logic [PC_W-1:0] brTarget_q, brTarget_d;
  logic [PC_W-1:0] regTarget_q, regTarget_d;

  logic [PC_W-1:0] nextPc;
  logic            fetchDone;
  logic            isMemOp;

  // A fetch completes only when we are actually requesting (FETCH, no halt)
  assign fetchDone = (state_q == S_FETCH) && !halt && imem_ack;
  // Loads (md=01) and stores both need the MEM phase
  assign isMemOp   = mw || (md == 2'b01);

  // State register; reset parks the sequencer in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: halt is only honoured in FETCH so in-flight work completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (imem_ack) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = isMemOp ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT: begin
        if (!halt) begin
          state_d = S_FETCH;
        end
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // Request, strobe and pulse outputs; forced low while reset is asserted so
  // an interrupted access is dropped immediately
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: imem_req = rst_n && !halt;
      S_MEM: begin
        dmem_req = rst_n;
        dmem_we  = rst_n && mwLat_q;
      end
      S_WB: begin
        rf_we  = rst_n && rwLat_q;
        retire = rst_n;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Resolve the following PC from the branch controls captured in EXEC
  always_comb begin
    nextPc = pc_q + PC_W'(1);
    case (bsLat_q)
      2'b01: begin
        if (taken_q) begin
          nextPc = brTarget_q;
        end
      end
      2'b10:   nextPc = regTarget_q;
      2'b11:   nextPc = brTarget_q;
      default: ;
    endcase
  end

  // Next values for IR, PC, retire counter and the EXEC snapshot of decoder flags
  always_comb begin
    ir_d        = ir_q;
    pc_d        = pc_q;
    instret_d   = instret_q;
    taken_d     = taken_q;
    bsLat_d     = bsLat_q;
    rwLat_d     = rwLat_q;
    mwLat_d     = mwLat_q;
    brTarget_d  = brTarget_q;
    regTarget_d = regTarget_q;
    if (fetchDone) begin
      ir_d = imem_rdata;
    end
    if (state_q == S_EXEC) begin
      taken_d     = (bs == 2'b01) && (zero ^ ps);
      bsLat_d     = bs;
      rwLat_d     = rw;
      mwLat_d     = mw;
      brTarget_d  = br_target;
      regTarget_d = reg_target;
    end
    if (state_q == S_WB) begin
      pc_d      = nextPc;
      instret_d = instret_q + 32'd1;
    end
  end

  // Architectural and snapshot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      instret_q   <= '0;
      taken_q     <= 1'b0;
      bsLat_q     <= 2'b00;
      rwLat_q     <= 1'b0;
      mwLat_q     <= 1'b0;
      brTarget_q  <= '0;
      regTarget_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      instret_q   <= instret_d;
      taken_q     <= taken_d;
      bsLat_q     <= bsLat_d;
      rwLat_q     <= rwLat_d;
      mwLat_q     <= mwLat_d;
      brTarget_q  <= brTarget_d;
      regTarget_q <= regTarget_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Testbench for inst_seq_ctrl: an instruction-level model expands each
// directed instruction into its expected per-cycle output timeline, and a
// single compare process checks the DUT against it on every falling edge.
module tb_inst_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        rw;
  logic        mw;
  logic [1:0]  md;
  logic [1:0]  bs;
  logic        ps;
  logic        zero;
  logic [31:0] br_target;
  logic [31:0] reg_target;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        halted;

  inst_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .rw         (rw),
    .mw         (mw),
    .md         (md),
    .bs         (bs),
    .ps         (ps),
    .zero       (zero),
    .br_target  (br_target),
    .reg_target (reg_target),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .pc         (pc),
    .retire     (retire),
    .instret    (instret),
    .halted     (halted)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        imemReq;
    logic        dmemReq;
    logic        dmemWe;
    logic        rfWe;
    logic        retire;
    logic        halted;
    logic [31:0] pc;
    logic [31:0] instret;
    logic [31:0] ir;
  } exp_t;

  exp_t        expQ[$];
  int          errors = 0;
  int          checks = 0;

  // Architectural model state
  logic [31:0] mPc   = 32'd0;
  logic [31:0] mInst = 32'd0;
  logic [31:0] mIr   = 32'd0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Compare DUT outputs against the expected timeline once per cycle
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkVal("imem_req",  32'(imem_req), 32'(e.imemReq));
      checkVal("dmem_req",  32'(dmem_req), 32'(e.dmemReq));
      if (e.dmemReq) checkVal("dmem_we", 32'(dmem_we), 32'(e.dmemWe));
      checkVal("rf_we",     32'(rf_we),    32'(e.rfWe));
      checkVal("retire",    32'(retire),   32'(e.retire));
      checkVal("halted",    32'(halted),   32'(e.halted));
      checkVal("pc",        pc,            e.pc);
      checkVal("imem_addr", imem_addr,     e.pc);
      checkVal("instret",   instret,       e.instret);
      checkVal("ir",        ir,            e.ir);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input bit iReq, input bit dReq, input bit dWe,
                         input bit rf, input bit ret, input bit hlt);
    exp_t e;
    e.imemReq = iReq;
    e.dmemReq = dReq;
    e.dmemWe  = dWe;
    e.rfWe    = rf;
    e.retire  = ret;
    e.halted  = hlt;
    e.pc      = mPc;
    e.instret = mInst;
    e.ir      = mIr;
    expQ.push_back(e);
  endtask

  // One instruction: fetch with fWait stall cycles, decode, exec, optional
  // memory phase with dWait stall cycles, writeback. Spurious acks and an
  // inverted zero flag are driven in the phases where they must be ignored.
  task automatic applyStimulus(input logic [31:0] rdata, input bit iRw, input bit iMw,
                               input logic [1:0] iMd, input logic [1:0] iBs,
                               input bit iPs, input bit iZero,
                               input logic [31:0] brT, input logic [31:0] regT,
                               input int fWait, input int dWait, input bit holdHalt);
    bit isMem;
    bit taken;
    isMem = iMw || (iMd == 2'b01);
    taken = (iBs == 2'b01) && (iZero ^ iPs);
    for (int k = 0; k <= fWait; k++) begin
      nextCycle();
      rw = iRw; mw = iMw; md = iMd; bs = iBs; ps = iPs;
      br_target = brT; reg_target = regT;
      zero = ~iZero;
      halt = 1'b0;
      imem_ack = (k == fWait);
      imem_rdata = (k == fWait) ? rdata : (32'hDEAD0000 | 32'(k));
      dmem_ack = 1'b1;
      pushExp(1, 0, 0, 0, 0, 0);
      if (k == fWait) mIr = rdata;
    end
    nextCycle();
    imem_ack = 1'b1; imem_rdata = 32'hBAD00001; dmem_ack = 1'b1; halt = 1'b1;
    pushExp(0, 0, 0, 0, 0, 0);
    nextCycle();
    imem_ack = 1'b0; dmem_ack = 1'b1; zero = iZero; halt = holdHalt;
    pushExp(0, 0, 0, 0, 0, 0);
    if (isMem) begin
      for (int j = 0; j <= dWait; j++) begin
        nextCycle();
        zero = ~iZero; imem_ack = 1'b1; imem_rdata = 32'hBAD00002;
        dmem_ack = (j == dWait); halt = holdHalt;
        pushExp(0, 1, iMw, 0, 0, 0);
      end
    end
    nextCycle();
    zero = ~iZero; imem_ack = 1'b1; imem_rdata = 32'hBAD00003; dmem_ack = 1'b1; halt = holdHalt;
    pushExp(0, 0, 0, iRw, 1, 0);
    mInst = mInst + 32'd1;
    if (iBs == 2'b10)                  mPc = regT;
    else if (iBs == 2'b11 || taken)    mPc = brT;
    else                               mPc = mPc + 32'd1;
  endtask

  // Fetch cycles with no ack
  task automatic fetchStall(input int n);
    for (int k = 0; k < n; k++) begin
      nextCycle();
      halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      pushExp(1, 0, 0, 0, 0, 0);
    end
  endtask

  // Halt entry from FETCH, n cycles parked, then release
  task automatic doHalt(input int n);
    nextCycle();
    halt = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    pushExp(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) begin
      nextCycle();
      halt = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD00004; dmem_ack = 1'b1;
      pushExp(0, 0, 0, 0, 0, 1);
    end
    nextCycle();
    halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    pushExp(0, 0, 0, 0, 0, 1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checkVal(name, act, req);
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    rw = 1'b0; mw = 1'b0; md = 2'b00; bs = 2'b00; ps = 1'b0; zero = 1'b0;
    br_target = '0; reg_target = '0; dmem_ack = 1'b0;
    #12;
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_rf_we",    32'(rf_we),    32'd0);
    checkOutput("rst_retire",   32'(retire),   32'd0);
    checkOutput("rst_halted",   32'(halted),   32'd0);
    checkOutput("rst_pc",       pc,            32'd0);
    checkOutput("rst_instret",  instret,       32'd0);
    checkOutput("rst_ir",       ir,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Move away from the reset PC, then reset in the middle of a fetch
    applyStimulus(32'h0000A010, 0, 0, 2'b00, 2'b10, 0, 0, 32'h0, 32'h10, 0, 0, 0);
    fetchStall(2);
    nextCycle();
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD000FF;
    #1;
    checkOutput("midrst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("midrst_pc",       pc,            32'd0);
    checkOutput("midrst_instret",  instret,       32'd0);
    checkOutput("midrst_ir",       ir,            32'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b0;
    mPc = 32'd0; mInst = 32'd0; mIr = 32'd0;

    // JMR to 5 (fresh fetch at 0 with one stall), then ADD at 5
    applyStimulus(32'h0000A005, 0, 0, 2'b00, 2'b10, 0, 0, 32'h0, 32'h5, 1, 0, 0);
    applyStimulus(32'h00001234, 1, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("pin_add_pc", mPc, 32'd6);
    // LD with dmem ack delayed 3 cycles, ST with fetch stall
    applyStimulus(32'h00002001, 1, 0, 2'b01, 2'b00, 0, 0, 32'h0, 32'h0, 0, 3, 0);
    checkOutput("pin_ld_pc", mPc, 32'd7);
    applyStimulus(32'h00003002, 0, 1, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 2, 0, 0);
    // BZ taken / not taken, BNZ not taken / taken
    applyStimulus(32'h00004003, 0, 0, 2'b00, 2'b01, 0, 1, 32'h40, 32'h0, 0, 0, 0);
    checkOutput("pin_bz_taken_pc", mPc, 32'h40);
    applyStimulus(32'h00004004, 0, 0, 2'b00, 2'b01, 0, 0, 32'h99, 32'h0, 0, 0, 0);
    applyStimulus(32'h00005005, 0, 0, 2'b00, 2'b01, 1, 1, 32'h99, 32'h0, 0, 0, 0);
    checkOutput("pin_bnz_fall_pc", mPc, 32'h42);
    applyStimulus(32'h00005006, 0, 0, 2'b00, 2'b01, 1, 0, 32'h80, 32'h0, 0, 0, 0);
    // JMR, JML, wrap at the top of the address space
    applyStimulus(32'h00006007, 0, 0, 2'b00, 2'b10, 0, 0, 32'h777, 32'h123, 0, 0, 0);
    checkOutput("pin_jmr_pc", mPc, 32'h123);
    applyStimulus(32'h00007008, 1, 0, 2'b00, 2'b11, 0, 0, 32'h200, 32'h555, 0, 0, 0);
    applyStimulus(32'h00006009, 0, 0, 2'b00, 2'b10, 0, 0, 32'h0, 32'hFFFFFFFF, 0, 0, 0);
    applyStimulus(32'h00000000, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("pin_wrap_pc", mPc, 32'd0);
    // Halt raised during EXEC: instruction retires, then HALT, then resume
    applyStimulus(32'h0000100A, 1, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    doHalt(3);
    applyStimulus(32'h0000100B, 1, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("pin_final_pc", mPc, 32'd2);
    checkOutput("pin_final_instret", mInst, 32'd14);
    fetchStall(1);
    @(negedge clk);
    @(negedge clk);
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
